// File: rtl/fetch_pkg.sv
// Shared defaults and helpers for the fetch stage and its interrupt arbiter.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT       = 32;
  localparam logic [31:0] NOP_INSTR_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] VEC_BASE_DEFAULT   = 32'h0000_0004;
  localparam int unsigned VEC_STRIDE_DEFAULT = 4;

  // Width of an interrupt id; a single source still needs one bit.
  function automatic int unsigned IRQ_ID_W(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fetch_irq_unit_if.sv
// Signal bundle between the fetch stage (master) and the rest of the pipeline / imem (slave).
interface fetch_irq_unit_if #(
  parameter int unsigned XLEN    = fetch_pkg::XLEN_DEFAULT,
  parameter int unsigned NUM_IRQ = 4
);
  localparam int unsigned IdW = fetch_pkg::IRQ_ID_W(NUM_IRQ);

  logic               stall;
  logic               flush;
  logic               branch;
  logic [XLEN-1:0]    pc_ex;
  logic               rti;
  logic               rsi;
  logic [NUM_IRQ-1:0] irq_in;
  logic               irq_en;
  logic               prog_en;
  logic [XLEN-1:0]    prog_addr;
  logic [XLEN-1:0]    imem_addr;
  logic [XLEN-1:0]    imem_rdata;
  logic [XLEN-1:0]    instruction_dec;
  logic [XLEN-1:0]    pc_dec;
  logic               irq_active;
  logic [IdW-1:0]     irq_id;
  logic [XLEN-1:0]    epc;

  modport master (
    input  stall, flush, branch, pc_ex, rti, rsi, irq_in, irq_en, prog_en, prog_addr,
           imem_rdata,
    output imem_addr, instruction_dec, pc_dec, irq_active, irq_id, epc
  );

  modport slave (
    output stall, flush, branch, pc_ex, rti, rsi, irq_in, irq_en, prog_en, prog_addr,
           imem_rdata,
    input  imem_addr, instruction_dec, pc_dec, irq_active, irq_id, epc
  );

endinterface

// File: rtl/irq_arbiter.sv
// Rising-edge capture of interrupt lines into a pending set, lowest index wins.
module irq_arbiter
  import fetch_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 4,
  localparam int unsigned IdW    = IRQ_ID_W(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               take,
  output logic               any_pending,
  output logic [IdW-1:0]     winner
);

  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] clr_mask;

  always_comb begin
    winner = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (pending_q[i]) winner = IdW'(i);
    end
  end

  assign any_pending = |pending_q;
  assign clr_mask    = take ? (NUM_IRQ'(1) << winner) : '0;

  // A fresh edge on the bit being cleared keeps it pending.
  assign pending_d = (pending_q & ~clr_mask) | (irq_in & ~irq_prev_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
    end else begin
      irq_prev_q <= irq_in;
      pending_q  <= pending_d;
    end
  end

endmodule

// File: rtl/fetch_irq_unit.sv
// Fetch stage: PC, next-PC selection, interrupt entry/return and the decode register.
module fetch_irq_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN       = XLEN_DEFAULT,
  parameter int unsigned     NUM_IRQ    = 4,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEFAULT),
  parameter logic [XLEN-1:0] VEC_BASE   = XLEN'(VEC_BASE_DEFAULT),
  parameter int unsigned     VEC_STRIDE = VEC_STRIDE_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR  = XLEN'(NOP_INSTR_DEFAULT)
) (
  input logic              clk,
  input logic              rst,
  fetch_irq_unit_if.master bus
);

  localparam int unsigned IdW = IRQ_ID_W(NUM_IRQ);

  logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_dec_q, pc_dec_d;
  logic            irq_active_q, irq_active_d;
  logic [IdW-1:0]  irq_id_q, irq_id_d;
  logic            any_pending;
  logic [IdW-1:0]  winner;
  logic            take;

  irq_arbiter #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq_arbiter (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (bus.irq_in),
    .take        (take),
    .any_pending (any_pending),
    .winner      (winner)
  );

  assign pc_plus4 = pc_q + XLEN'(4);

  // rti/rsi defer any pending interrupt by at least one cycle.
  assign take = bus.irq_en & ~irq_active_q & ~bus.prog_en & ~bus.stall & ~bus.rti & ~bus.rsi &
                any_pending;

  assign bus.imem_addr = bus.prog_en ? bus.prog_addr : pc_q;

  always_comb begin
    pc_d = pc_plus4;
    if (bus.prog_en) begin
      pc_d = pc_q;
    end else if (take) begin
      pc_d = VEC_BASE + XLEN'(winner) * XLEN'(VEC_STRIDE);
    end else if (bus.rti) begin
      pc_d = epc_q;
    end else if (bus.branch) begin
      pc_d = bus.pc_ex;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    irq_active_d = irq_active_q;
    irq_id_d     = irq_id_q;
    epc_d        = epc_q;
    if (take) begin
      irq_active_d = 1'b1;
      irq_id_d     = winner;
      epc_d        = bus.branch ? bus.pc_ex : pc_plus4;
    end else begin
      if (bus.rti || bus.rsi) irq_active_d = 1'b0;
      if (bus.rsi)            epc_d        = '0;
    end
  end

  always_comb begin
    instr_d  = bus.imem_rdata;
    pc_dec_d = pc_plus4;
    if (bus.flush || bus.branch || bus.rti || bus.prog_en) begin
      instr_d  = NOP_INSTR;
      pc_dec_d = '0;
    end else if (bus.stall) begin
      instr_d  = instr_q;
      pc_dec_d = pc_dec_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      epc_q        <= '0;
      instr_q      <= NOP_INSTR;
      pc_dec_q     <= '0;
      irq_active_q <= 1'b0;
      irq_id_q     <= '0;
    end else begin
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      instr_q      <= instr_d;
      pc_dec_q     <= pc_dec_d;
      irq_active_q <= irq_active_d;
      irq_id_q     <= irq_id_d;
    end
  end

  assign bus.instruction_dec = instr_q;
  assign bus.pc_dec          = pc_dec_q;
  assign bus.irq_active      = irq_active_q;
  assign bus.irq_id          = irq_id_q;
  assign bus.epc             = epc_q;

endmodule

// File: tb/tb_fetch_irq_unit.sv
// Directed plus randomized bench for fetch_irq_unit against a rule-level model.
module tb_fetch_irq_unit;

  localparam int unsigned NUM_IRQ = 4;
  localparam logic [31:0] NOP     = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   asserts  = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fetch_irq_unit_if #(.XLEN(32), .NUM_IRQ(NUM_IRQ)) bus ();

  fetch_irq_unit #(.XLEN(32), .NUM_IRQ(NUM_IRQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  assign bus.imem_rdata = pat(bus.imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state after each edge, following the fetch rules directly.
  logic [31:0] m_pc, m_epc, m_instr, m_pcdec, m_addr;
  logic        m_act;
  int          m_id, m_k;
  bit          m_pend [NUM_IRQ];
  bit          m_prev [NUM_IRQ];
  bit          m_any, m_take;

  always_comb begin
    m_k   = 0;
    m_any = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (m_pend[i]) begin
        m_k   = i;
        m_any = 1'b1;
      end
    end
    m_take = bus.irq_en && !m_act && !bus.prog_en && !bus.stall && !bus.rti && !bus.rsi && m_any;
    m_addr = bus.prog_en ? bus.prog_addr : m_pc;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc    <= 32'h0;
      m_epc   <= 32'h0;
      m_instr <= NOP;
      m_pcdec <= 32'h0;
      m_act   <= 1'b0;
      m_id    <= 0;
      for (int i = 0; i < NUM_IRQ; i++) begin
        m_pend[i] <= 1'b0;
        m_prev[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        m_prev[i] <= bus.irq_in[i];
        m_pend[i] <= (bus.irq_in[i] && !m_prev[i]) || (m_pend[i] && !(m_take && m_k == i));
      end
      if (bus.prog_en)     m_pc <= m_pc;
      else if (m_take)     m_pc <= 32'(32'h4 + m_k * 4);
      else if (bus.rti)    m_pc <= m_epc;
      else if (bus.branch) m_pc <= bus.pc_ex;
      else if (!bus.stall) m_pc <= m_pc + 32'd4;
      if (m_take) begin
        m_act <= 1'b1;
        m_id  <= m_k;
        m_epc <= bus.branch ? bus.pc_ex : m_pc + 32'd4;
      end else begin
        if (bus.rti || bus.rsi) m_act <= 1'b0;
        if (bus.rsi)            m_epc <= 32'h0;
      end
      if (bus.flush || bus.branch || bus.rti || bus.prog_en) begin
        m_instr <= NOP;
        m_pcdec <= 32'h0;
      end else if (!bus.stall) begin
        m_instr <= pat(m_addr);
        m_pcdec <= m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    chk("imem_addr", bus.imem_addr, m_addr);
    chk("instruction_dec", bus.instruction_dec, m_instr);
    chk("pc_dec", bus.pc_dec, m_pcdec);
    chk("irq_active", 32'(bus.irq_active), 32'(m_act));
    chk("irq_id", 32'(bus.irq_id), 32'(m_id));
    chk("epc", bus.epc, m_epc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    bus.stall  = 1'b0;
    bus.flush  = 1'b0;
    bus.branch = 1'b0;
    bus.rti    = 1'b0;
    bus.rsi    = 1'b0;
  endtask

  initial begin
    clear_ctl();
    bus.pc_ex     = '0;
    bus.irq_in    = '0;
    bus.irq_en    = 1'b0;
    bus.prog_en   = 1'b0;
    bus.prog_addr = '0;
    #12;
    tick();
    rst = 1'b0;
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_instr", bus.instruction_dec, NOP);
    chk("rst_pcdec", bus.pc_dec, 32'h0);
    chk("rst_active", 32'(bus.irq_active), 32'h0);
    chk("rst_epc", bus.epc, 32'h0);

    tick();
    chk("seq_addr4", bus.imem_addr, 32'h4);
    chk("seq_pcdec4", bus.pc_dec, 32'h4);
    chk("seq_instr0", bus.instruction_dec, pat(32'h0));
    tick();
    chk("seq_addr8", bus.imem_addr, 32'h8);
    chk("seq_instr4", bus.instruction_dec, pat(32'h4));
    tick();
    tick();
    chk("seq_addr10", bus.imem_addr, 32'h10);

    // Branch together with stall still redirects and flushes decode.
    bus.branch = 1'b1;
    bus.stall  = 1'b1;
    bus.pc_ex  = 32'h100;
    tick();
    chk("br_addr", bus.imem_addr, 32'h100);
    chk("br_instr", bus.instruction_dec, NOP);
    chk("br_pcdec", bus.pc_dec, 32'h0);
    bus.stall = 1'b0;
    bus.pc_ex = 32'h1C;
    tick();
    bus.branch = 1'b0;
    bus.irq_en = 1'b1;
    bus.irq_in = 4'b0110;
    tick();
    chk("pre_take_addr", bus.imem_addr, 32'h20);
    tick();
    chk("take1_addr", bus.imem_addr, 32'h8);
    chk("take1_epc", bus.epc, 32'h24);
    chk("take1_id", 32'(bus.irq_id), 32'h1);
    chk("take1_active", 32'(bus.irq_active), 32'h1);
    chk("take1_instr", bus.instruction_dec, pat(32'h20));

    bus.rsi = 1'b1;
    tick();
    chk("rsi_active", 32'(bus.irq_active), 32'h0);
    chk("rsi_epc", bus.epc, 32'h0);
    chk("rsi_addr", bus.imem_addr, 32'hC);
    bus.rsi = 1'b0;
    tick();
    chk("take2_addr", bus.imem_addr, 32'hC);
    chk("take2_id", 32'(bus.irq_id), 32'h2);
    chk("take2_epc", bus.epc, 32'h10);

    bus.irq_in = 4'b0111;
    tick();
    chk("locked_active", 32'(bus.irq_active), 32'h1);
    chk("locked_addr", bus.imem_addr, 32'h10);
    bus.rti = 1'b1;
    tick();
    chk("rti_addr", bus.imem_addr, 32'h10);
    chk("rti_active", 32'(bus.irq_active), 32'h0);
    bus.rti = 1'b0;
    tick();
    chk("take0_addr", bus.imem_addr, 32'h4);
    chk("take0_id", 32'(bus.irq_id), 32'h0);
    chk("take0_epc", bus.epc, 32'h14);
    bus.rti = 1'b1;
    tick();
    bus.rti    = 1'b0;
    bus.irq_in = 4'b0110;
    tick();

    // Edge during a three-cycle stall is held off until the stall drops.
    bus.stall  = 1'b1;
    bus.irq_in = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr", bus.imem_addr, 32'h18);
      chk("stall_active", 32'(bus.irq_active), 32'h0);
    end
    bus.stall = 1'b0;
    tick();
    chk("unstall_take_addr", bus.imem_addr, 32'h4);
    chk("unstall_take_epc", bus.epc, 32'h1C);
    bus.rti = 1'b1;
    tick();
    bus.rti = 1'b0;

    bus.prog_en   = 1'b1;
    bus.prog_addr = 32'h40;
    #1;
    chk("prog_addr", bus.imem_addr, 32'h40);
    tick();
    chk("prog_hold_addr", bus.imem_addr, 32'h40);
    chk("prog_instr", bus.instruction_dec, NOP);
    bus.prog_en = 1'b0;
    #1;
    chk("prog_resume", bus.imem_addr, 32'h1C);

    for (int n = 0; n < 3000; n++) begin
      tick();
      rst        = ($urandom_range(0, 299) == 0);
      bus.stall  = ($urandom_range(0, 99) < 20);
      bus.flush  = ($urandom_range(0, 99) < 10);
      bus.branch = ($urandom_range(0, 99) < 10);
      bus.rti    = ($urandom_range(0, 99) < 5);
      bus.rsi    = ($urandom_range(0, 99) < 6);
      bus.irq_en = ($urandom_range(0, 99) < 85);
      bus.prog_en = ($urandom_range(0, 99) < 5);
      bus.pc_ex     = $urandom() & 32'hFFFF_FFFC;
      bus.prog_addr = $urandom();
      if ($urandom_range(0, 99) < 25) bus.irq_in = bus.irq_in ^ 4'($urandom_range(0, 15));
    end
    rst = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
